// File: rtl/regfile_dumper.sv
// regfile_dumper: walks a contiguous, optionally wrapping, register range
// through one regfile read port and streams {address, data} pairs out over
// a valid/ready handshake. Read-only: it drives the read address and
// nothing else on the regfile.
module regfile_dumper #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_sent
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     words_sent_q, words_sent_d;
    logic                handshake_s;

    assign handshake_s = out_valid_q && out_ready;

    // Next-state logic and registered-output precompute (flags follow state_d).
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        end_d        = end_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        words_sent_d = words_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    cur_d        = first_addr;
                    end_d        = last_addr;
                    words_sent_d = '0;
                    state_d      = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    // Snapshot the regfile value at the end of this cycle.
                    out_data_d = rd;
                    out_addr_d = cur_q;
                    out_last_d = (cur_q == end_q);
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake_s) begin
                    // The handshake counts even when abort arrives with it.
                    words_sent_d = words_sent_q + {{ADDR_W{1'b0}}, 1'b1};
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else if (out_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d = ST_FETCH;
                    end
                end else if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_valid_d = (state_d == ST_SEND);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            end_q        <= '0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            end_q        <= end_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Read address decoded from registered state only, so it is clean at the edge.
    always_comb begin
        if ((state_q == ST_FETCH) || (state_q == ST_SEND)) begin
            ra = cur_q;
        end else begin
            ra = '0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed testbench for regfile_dumper with a behavioural regfile model.
module tb_regfile_dumper;

    logic        clk = 1'b0;
    logic        reset, start, abort, out_ready;
    logic [4:0]  first_addr, last_addr, ra, out_addr;
    logic [31:0] rd, out_data;
    logic        out_valid, out_last, busy, done;
    logic [5:0]  words_sent;
    logic [31:0] regs [32];

    int vectors = 0;
    int miscompares = 0;

    regfile_dumper #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .ra(ra), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    // Regfile read port: $0 always reads zero.
    assign rd = (ra == 5'd0) ? 32'd0 : regs[ra];

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : regs[a];
    endfunction

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Full-rate dump with out_ready held high; checks every word and the timing.
    task automatic dump_expect(input logic [4:0] f, input logic [4:0] l, input int n);
        logic [4:0] a;
        out_ready = 1'b1;
        start_dump(f, l);
        for (int k = 0; k < n; k++) begin
            a = f + 5'(k);
            chk("fetch_valid", {63'd0, out_valid}, 64'd0);
            chk("fetch_busy", {63'd0, busy}, 64'd1);
            chk("fetch_ra", {59'd0, ra}, {59'd0, a});
            if (k == 0) chk("ws_cleared", {58'd0, words_sent}, 64'd0);
            step();
            chk("send_valid", {63'd0, out_valid}, 64'd1);
            chk("send_addr", {59'd0, out_addr}, {59'd0, a});
            chk("send_data", {32'd0, out_data}, {32'd0, model_rd(a)});
            chk("send_last", {63'd0, out_last}, (k == n - 1) ? 64'd1 : 64'd0);
            step();
        end
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("done_valid", {63'd0, out_valid}, 64'd0);
        chk("done_ws", {58'd0, words_sent}, 64'(n));
        step();
        chk("done_fall", {63'd0, done}, 64'd0);
        chk("busy_fall", {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_last"}, {63'd0, out_last}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_ra"}, {59'd0, ra}, 64'd0);
        chk({tag, "_addr"}, {59'd0, out_addr}, 64'd0);
        chk({tag, "_data"}, {32'd0, out_data}, 64'd0);
        chk({tag, "_ws"}, {58'd0, words_sent}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
        regs[0]    = 32'd0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        first_addr = 5'd0;
        last_addr  = 5'd0;
        step();
        step();
        reset = 1'b0;
        chk_reset_state("por");

        // Single word.
        regs[7] = 32'hDEADBEEF;
        dump_expect(5'd7, 5'd7, 1);

        // Full dump, then wrap.
        regs[7] = 32'h107;
        dump_expect(5'd0, 5'd31, 32);
        dump_expect(5'd30, 5'd1, 4);

        // Abort in IDLE blocks a simultaneous start.
        first_addr = 5'd3;
        last_addr  = 5'd3;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", {63'd0, busy}, 64'd0);
        chk("idle_abort_ra", {59'd0, ra}, 64'd0);

        // Backpressure on the second word of 3..5, with $4 rewritten mid-stall.
        out_ready = 1'b1;
        start_dump(5'd3, 5'd5);
        step();
        chk("bp_w0_addr", {59'd0, out_addr}, 64'd3);
        step();
        chk("bp_w1_fetch_ra", {59'd0, ra}, 64'd4);
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_addr", {59'd0, out_addr}, 64'd4);
            chk("bp_hold_data", {32'd0, out_data}, 64'h104);
            chk("bp_hold_ws", {58'd0, words_sent}, 64'd1);
            if (i == 2) regs[4] = 32'h5555_AAAA;
            step();
        end
        out_ready = 1'b1;
        chk("bp_release_data", {32'd0, out_data}, 64'h104);
        step();
        chk("bp_w2_fetch_ra", {59'd0, ra}, 64'd5);
        chk("bp_ws2", {58'd0, words_sent}, 64'd2);
        step();
        chk("bp_w2_addr", {59'd0, out_addr}, 64'd5);
        chk("bp_w2_last", {63'd0, out_last}, 64'd1);
        step();
        chk("bp_done", {63'd0, done}, 64'd1);
        chk("bp_ws3", {58'd0, words_sent}, 64'd3);
        step();
        regs[4] = 32'h104;

        // Abort during SEND of word 9; a mid-dump start is ignored.
        out_ready = 1'b1;
        start_dump(5'd0, 5'd31);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("ab_addr", {59'd0, out_addr}, 64'(k));
            if (k == 4) begin
                first_addr = 5'd20;
                last_addr  = 5'd20;
                start      = 1'b1;
            end
            step();
            start = 1'b0;
        end
        chk("ab_fetch9_ra", {59'd0, ra}, 64'd9);
        out_ready = 1'b0;
        step();
        chk("ab_send9_valid", {63'd0, out_valid}, 64'd1);
        chk("ab_send9_addr", {59'd0, out_addr}, 64'd9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_valid_drop", {63'd0, out_valid}, 64'd0);
        chk("ab_busy", {63'd0, busy}, 64'd0);
        chk("ab_no_done", {63'd0, done}, 64'd0);
        chk("ab_ws", {58'd0, words_sent}, 64'd9);
        step();
        chk("ab_no_done2", {63'd0, done}, 64'd0);
        chk("ab_ws_hold", {58'd0, words_sent}, 64'd9);
        dump_expect(5'd2, 5'd2, 1);

        // Reset mid-dump with start/abort asserted alongside.
        out_ready = 1'b1;
        start_dump(5'd10, 5'd20);
        step();
        step();
        step();
        chk("rst_pre_valid", {63'd0, out_valid}, 64'd1);
        chk("rst_pre_addr", {59'd0, out_addr}, 64'd11);
        reset      = 1'b1;
        start      = 1'b1;
        abort      = 1'b1;
        first_addr = 5'd1;
        last_addr  = 5'd2;
        step();
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        chk_reset_state("rst_mid");
        step();
        chk("rst_after_busy", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Sequential reader for the MIPS pipeline register file: on a start command it walks a contiguous, optionally wrapping, range of registers through one regfile read port. It streams each `{address, data}` pair out over a valid/ready handshake. It sits beside the `regfile` on a spare read port (debug/trace path) and drives only the read address, never the write port.

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register address width (32 registers).
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin a dump; accepted only in IDLE.
- `abort` in 1: cancel the dump in progress.
- `first_addr` in ADDR_W: first register of the range; sampled on an accepted start.
- `last_addr` in ADDR_W: last register of the range; sampled on an accepted start.
- `ra` out ADDR_W: read address to the regfile port.
- `rd` in DATA_W: combinational read data from the regfile port.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: sink accepts the word.
- `out_addr` out ADDR_W: register number of the output word.
- `out_data` out DATA_W: register value.
- `out_last` out 1: final word of the dump.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last handshake.
- `words_sent` out ADDR_W+1: handshakes completed in the current or most recent dump.

## Operation
- States are IDLE, FETCH, SEND and DONE.
- IDLE:
  - `ra` = 0.
  - If `start` and not `abort`: latch `first_addr` into `cur` and `last_addr` into `end`; clear `words_sent`; go to FETCH.
- FETCH:
  - `ra` = `cur`.
  - On the edge, register `rd` into `out_data`, `cur` into `out_addr`, and `(cur == end)` into `out_last`.
  - Go to SEND.
- SEND:
  - `out_valid` = 1 and `ra` = `cur`.
  - `out_data`, `out_addr` and `out_last` stay stable until handshake (`out_valid && out_ready`).
  - On handshake, `words_sent` += 1:
    - If `out_last`, go to DONE.
    - Otherwise `cur` = `cur` + 1 mod 2^ADDR_W, then go to FETCH.
- DONE: `done` = 1 for this cycle only; go to IDLE.
- Range and wrap:
  - Word count = ((`end` − `first`) mod 32) + 1.
  - When `first_addr > last_addr`, the dump wraps 31→0. Example: 30..1 yields 30, 31, 0, 1.
  - `first_addr == last_addr` gives exactly one word.
  - A full dump of 32 words (e.g. 0..31 or 5..4) makes `words_sent` = 32, which is why it is ADDR_W+1 bits wide.
- Register $0 returns whatever the regfile presents (always 0); the dumper does not special-case it.
- Snapshot semantics: each value is the regfile content sampled at the end of its FETCH cycle. Regfile writes after that edge are not reflected in the held word.
- Command priority:
  - `abort` in FETCH, SEND or DONE: next state IDLE, `out_valid` drops next cycle, no `done` pulse, `words_sent` holds.
  - `abort` in IDLE is ignored, and it blocks a simultaneous `start`.
  - `start` outside IDLE is ignored.
  - An `abort` in the same cycle as a SEND handshake: the handshake counts, then the block goes to IDLE with no `done`.
- Reset (any state, including mid-dump):
  - State goes to IDLE.
  - `out_valid`, `out_last`, `busy` and `done` go to 0.
  - `ra`, `out_addr`, `out_data` and `words_sent` go to 0.

## Timing
- All outputs are registered except `ra`, which is decoded from state/`cur` and glitch-free at the edge.
- Start latency: start accepted at edge N means FETCH in cycle N+1 and `out_valid` high in cycle N+2.
- Peak throughput is one word per 2 cycles (FETCH + SEND). Each cycle `out_ready` stays low adds one cycle.
- `done` is high in the cycle after the final handshake. `busy` falls in the cycle after `done`, and `start` may be accepted in that same cycle.
- `rd` must settle combinationally within the FETCH cycle. No pipelining of `rd` is assumed.

## Test plan
- Single word: regfile $7 = 0xDEADBEEF, `start` with 7..7, `out_ready` = 1 → one word `{7, 0xDEADBEEF}` with `out_last` = 1; `out_valid` in cycle N+2, `done` in cycle N+3, `words_sent` = 1.
- Full dump: $i = 0x100 + i (with $0 = 0), `start` 0..31, `out_ready` always 1 → 32 words in order; $0 reads 0; `out_last` only on address 31; exactly 64 cycles from the first FETCH to `done`; `words_sent` = 32.
- Wrap: `start` 30..1 → addresses 30, 31, 0, 1, with `out_last` on 1; `words_sent` = 4.
- Backpressure: 3..5 with `out_ready` low for 5 cycles on the second word → `out_addr`/`out_data` for $4 held constant throughout; no word lost or duplicated; snapshot value retained even if $4 is written during the stall.
- Abort / start-while-busy: 0..31, `start` pulsed again mid-dump (ignored), `abort` asserted during the SEND of word 9 without ready → IDLE next cycle, no `done`, `words_sent` = 9; a new `start` 2..2 then works normally.
- Reset mid-dump: assert `reset` in SEND → the next cycle shows all outputs at reset values; `start`/`abort` in the same cycle as `reset` have no effect.
